// File: rtl/sd_xfer_sequencer_pkg.sv
// Shared types and constants for the SD host transaction sequencer:
// FSM state encoding, err_code values and the CMD12 (STOP_TRANSMISSION) index.
package sd_xfer_sequencer_pkg;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_CMD_ISSUE  = 4'd1,
        ST_CMD_WAIT   = 4'd2,
        ST_DAT_ISSUE  = 4'd3,
        ST_DAT_WAIT   = 4'd4,
        ST_STOP_ISSUE = 4'd5,
        ST_STOP_WAIT  = 4'd6,
        ST_DONE       = 4'd7,
        ST_ERR        = 4'd8
    } seq_state_t;

    typedef enum logic [2:0] {
        ERR_NONE        = 3'd0,
        ERR_CMD         = 3'd1,
        ERR_CMD_TIMEOUT = 3'd2,
        ERR_DAT         = 3'd3,
        ERR_DAT_TIMEOUT = 3'd4,
        ERR_STOP        = 3'd5
    } err_code_t;

    localparam logic [5:0] CMD12_INDEX = 6'd12;

    // A block count of zero is treated as a single block.
    function automatic logic [15:0] eff_blk_cnt(input logic [15:0] cnt);
        return (cnt == 16'd0) ? 16'd1 : cnt;
    endfunction

endpackage

// File: rtl/sd_xfer_watchdog.sv
// Wait-state watchdog: counts cycles while enabled, restarts from zero while
// cleared, and flags the cycle on which TIMEOUT_LIMIT wait cycles have elapsed.
module sd_xfer_watchdog #(
    parameter int                   TIMEOUT_W     = 16,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_LIMIT = 16'hFFFF
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clear,
    input  logic en,
    output logic timeout
);

    localparam logic [TIMEOUT_W-1:0] LAST_CNT = TIMEOUT_W'(TIMEOUT_LIMIT - 1);

    logic [TIMEOUT_W-1:0] cnt_q;
    logic [TIMEOUT_W-1:0] cnt_d;

    // Next count: zero while cleared, otherwise advance once per enabled cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout = en && (cnt_q == LAST_CNT);

endmodule

// File: rtl/sd_xfer_sequencer.sv
// SD host transaction sequencer: issues one command, optionally runs the DAT
// block once per block, and reports completion or an error code.
// Optional feature macro: SD_AUTO_CMD12_EN (multi-block transfers end with CMD12).
module sd_xfer_sequencer #(
    parameter int                   TIMEOUT_W     = 16,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_LIMIT = 16'hFFFF
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        req_go,
    input  logic [5:0]  req_index,
    input  logic [31:0] req_arg,
    input  logic        req_has_data,
    input  logic        req_write,
    input  logic [15:0] req_blk_cnt,
    output logic        cmd_start,
    output logic [5:0]  cmd_index_o,
    output logic [31:0] cmd_arg_o,
    input  logic        cmd_done,
    input  logic        cmd_err,
    output logic        dat_start,
    output logic        dat_write,
    input  logic        dat_blk_done,
    input  logic        dat_err,
    output logic        busy,
    output logic [15:0] blk_remaining,
    output logic        xfer_done,
    output logic        err_pulse,
    output logic [2:0]  err_code
);

    import sd_xfer_sequencer_pkg::*;

    seq_state_t  state_q, state_d;
    logic [5:0]  index_q, index_d;
    logic [31:0] arg_q, arg_d;
    logic        has_data_q, has_data_d;
    logic        write_q, write_d;
    logic [15:0] blk_rem_q, blk_rem_d;
    err_code_t   err_code_q, err_code_d;
`ifdef SD_AUTO_CMD12_EN
    logic        multi_q, multi_d;
`endif

    logic [15:0] req_blk_eff;
    logic        in_wait;
    logic        in_stop;
    logic        timeout;

    assign req_blk_eff = eff_blk_cnt(req_blk_cnt);
    assign in_wait = (state_q == ST_CMD_WAIT) || (state_q == ST_DAT_WAIT) ||
                     (state_q == ST_STOP_WAIT);
    assign in_stop = (state_q == ST_STOP_ISSUE) || (state_q == ST_STOP_WAIT);

    sd_xfer_watchdog #(
        .TIMEOUT_W     (TIMEOUT_W),
        .TIMEOUT_LIMIT (TIMEOUT_LIMIT)
    ) u_watchdog (
        .CLK     (CLK),
        .RESET   (RESET),
        .clear   (!in_wait),
        .en      (in_wait),
        .timeout (timeout)
    );

    // Next-state logic plus request latching, block countdown and error capture.
    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        arg_d      = arg_q;
        has_data_d = has_data_q;
        write_d    = write_q;
        blk_rem_d  = blk_rem_q;
        err_code_d = err_code_q;
`ifdef SD_AUTO_CMD12_EN
        multi_d    = multi_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_go) begin
                    index_d    = req_index;
                    arg_d      = req_arg;
                    has_data_d = req_has_data;
                    write_d    = req_write;
                    blk_rem_d  = req_has_data ? req_blk_eff : 16'd0;
                    err_code_d = ERR_NONE;
`ifdef SD_AUTO_CMD12_EN
                    multi_d    = req_has_data && (req_blk_eff > 16'd1);
`endif
                    state_d    = ST_CMD_ISSUE;
                end
            end
            ST_CMD_ISSUE: state_d = ST_CMD_WAIT;
            ST_CMD_WAIT: begin
                if (cmd_done) begin
                    if (cmd_err) begin
                        err_code_d = ERR_CMD;
                        state_d    = ST_ERR;
                    end else begin
                        state_d = has_data_q ? ST_DAT_ISSUE : ST_DONE;
                    end
                end else if (timeout) begin
                    err_code_d = ERR_CMD_TIMEOUT;
                    state_d    = ST_ERR;
                end
            end
            ST_DAT_ISSUE: state_d = ST_DAT_WAIT;
            ST_DAT_WAIT: begin
                if (dat_blk_done) begin
                    if (dat_err) begin
                        err_code_d = ERR_DAT;
                        state_d    = ST_ERR;
                    end else begin
                        blk_rem_d = blk_rem_q - 16'd1;
                        if (blk_rem_q != 16'd1) begin
                            state_d = ST_DAT_ISSUE;
                        end else begin
`ifdef SD_AUTO_CMD12_EN
                            state_d = multi_q ? ST_STOP_ISSUE : ST_DONE;
`else
                            state_d = ST_DONE;
`endif
                        end
                    end
                end else if (timeout) begin
                    err_code_d = ERR_DAT_TIMEOUT;
                    state_d    = ST_ERR;
                end
            end
`ifdef SD_AUTO_CMD12_EN
            ST_STOP_ISSUE: state_d = ST_STOP_WAIT;
            ST_STOP_WAIT: begin
                if (cmd_done) begin
                    if (cmd_err) begin
                        err_code_d = ERR_STOP;
                        state_d    = ST_ERR;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else if (timeout) begin
                    err_code_d = ERR_CMD_TIMEOUT;
                    state_d    = ST_ERR;
                end
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and latched-request registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            index_q    <= '0;
            arg_q      <= '0;
            has_data_q <= 1'b0;
            write_q    <= 1'b0;
            blk_rem_q  <= '0;
            err_code_q <= ERR_NONE;
`ifdef SD_AUTO_CMD12_EN
            multi_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            arg_q      <= arg_d;
            has_data_q <= has_data_d;
            write_q    <= write_d;
            blk_rem_q  <= blk_rem_d;
            err_code_q <= err_code_d;
`ifdef SD_AUTO_CMD12_EN
            multi_q    <= multi_d;
`endif
        end
    end

    assign cmd_start     = (state_q == ST_CMD_ISSUE) || (state_q == ST_STOP_ISSUE);
    assign cmd_index_o   = in_stop ? CMD12_INDEX : index_q;
    assign cmd_arg_o     = in_stop ? 32'd0 : arg_q;
    assign dat_start     = (state_q == ST_DAT_ISSUE);
    assign dat_write     = write_q;
    assign busy          = (state_q != ST_IDLE) && (state_q != ST_DONE) &&
                           (state_q != ST_ERR);
    assign blk_remaining = blk_rem_q;
    assign xfer_done     = (state_q == ST_DONE);
    assign err_pulse     = (state_q == ST_ERR);
    assign err_code      = err_code_q;

endmodule

// File: tb/tb_sd_xfer_sequencer.sv
// Directed self-checking bench for sd_xfer_sequencer (watchdog limit set to 16).
module tb_sd_xfer_sequencer;

    logic        CLK;
    logic        RESET;
    logic        req_go;
    logic [5:0]  req_index;
    logic [31:0] req_arg;
    logic        req_has_data;
    logic        req_write;
    logic [15:0] req_blk_cnt;
    logic        cmd_start;
    logic [5:0]  cmd_index_o;
    logic [31:0] cmd_arg_o;
    logic        cmd_done;
    logic        cmd_err;
    logic        dat_start;
    logic        dat_write;
    logic        dat_blk_done;
    logic        dat_err;
    logic        busy;
    logic [15:0] blk_remaining;
    logic        xfer_done;
    logic        err_pulse;
    logic [2:0]  err_code;

    int checks = 0;
    int passes = 0;
    int n_cmd_start = 0;
    int n_dat_start = 0;
    int n_xfer_done = 0;
    int n_err_pulse = 0;

    sd_xfer_sequencer #(
        .TIMEOUT_W     (16),
        .TIMEOUT_LIMIT (16'd16)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .req_go        (req_go),
        .req_index     (req_index),
        .req_arg       (req_arg),
        .req_has_data  (req_has_data),
        .req_write     (req_write),
        .req_blk_cnt   (req_blk_cnt),
        .cmd_start     (cmd_start),
        .cmd_index_o   (cmd_index_o),
        .cmd_arg_o     (cmd_arg_o),
        .cmd_done      (cmd_done),
        .cmd_err       (cmd_err),
        .dat_start     (dat_start),
        .dat_write     (dat_write),
        .dat_blk_done  (dat_blk_done),
        .dat_err       (dat_err),
        .busy          (busy),
        .blk_remaining (blk_remaining),
        .xfer_done     (xfer_done),
        .err_pulse     (err_pulse),
        .err_code      (err_code)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Pulse counters, sampled on the falling edge.
    always @(negedge CLK) begin
        if (cmd_start === 1'b1) n_cmd_start++;
        if (dat_start === 1'b1) n_dat_start++;
        if (xfer_done === 1'b1) n_xfer_done++;
        if (err_pulse === 1'b1) n_err_pulse++;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation still running, required finish");
        $fatal(1, "[TB] time bound expired");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue_req(input logic [5:0] idx, input logic [31:0] arg,
                             input logic hd, input logic wr, input logic [15:0] cnt);
        req_go = 1'b1; req_index = idx; req_arg = arg;
        req_has_data = hd; req_write = wr; req_blk_cnt = cnt;
        tick();
        req_go = 1'b0;
    endtask

    task automatic pulse_cmd_done(input logic e);
        cmd_done = 1'b1; cmd_err = e;
        tick();
        cmd_done = 1'b0; cmd_err = 1'b0;
    endtask

    task automatic pulse_dat_done(input logic e);
        dat_blk_done = 1'b1; dat_err = e;
        tick();
        dat_blk_done = 1'b0; dat_err = 1'b0;
    endtask

    task automatic test_reset();
        logic [63:0] outs;
        RESET = 1'b1;
        #2;
        outs = {cmd_start, dat_start, dat_write, busy, xfer_done, err_pulse, err_code,
                blk_remaining, cmd_index_o};
        checks++;
        if (outs !== 64'd0 || cmd_arg_o !== 32'd0)
            $display("[TB] FAIL reset_outputs: got %0h/%0h, required 0/0", outs, cmd_arg_o);
        else passes++;
        tick();
        RESET = 1'b0;
        tick();
    endtask

    task automatic test_non_data();
        int c0 = n_cmd_start;
        int d0 = n_dat_start;
        issue_req(6'd8, 32'h1AA, 1'b0, 1'b0, 16'd0);
        checks++;
        if ({cmd_start, busy, cmd_index_o} !== {1'b1, 1'b1, 6'd8} || cmd_arg_o !== 32'h1AA)
            $display("[TB] FAIL nd_issue: got start=%0b busy=%0b idx=%0d arg=%0h, required 1 1 8 1aa",
                     cmd_start, busy, cmd_index_o, cmd_arg_o);
        else passes++;
        checks++;
        if (blk_remaining !== 16'd0)
            $display("[TB] FAIL nd_blk_rem: got %0d, required 0", blk_remaining);
        else passes++;
        repeat (4) tick();
        checks++;
        if ({cmd_start, busy, xfer_done, cmd_index_o} !== {1'b0, 1'b1, 1'b0, 6'd8})
            $display("[TB] FAIL nd_wait: got start=%0b busy=%0b done=%0b idx=%0d, required 0 1 0 8",
                     cmd_start, busy, xfer_done, cmd_index_o);
        else passes++;
        pulse_cmd_done(1'b0);
        checks++;
        if ({xfer_done, busy, err_pulse} !== 3'b100)
            $display("[TB] FAIL nd_done: got done/busy/err=%b, required 100", {xfer_done, busy, err_pulse});
        else passes++;
        tick();
        checks++;
        if (xfer_done !== 1'b0 || n_cmd_start - c0 !== 1 || n_dat_start - d0 !== 0 || err_code !== 3'd0)
            $display("[TB] FAIL nd_after: got done=%0b cmd_starts=%0d dat_starts=%0d code=%0d, required 0 1 0 0",
                     xfer_done, n_cmd_start - c0, n_dat_start - d0, err_code);
        else passes++;
    endtask

    task automatic test_multi_read();
        int d0 = n_dat_start;
        int x0 = n_xfer_done;
        int c0 = n_cmd_start;
        issue_req(6'd18, 32'h200, 1'b1, 1'b0, 16'd3);
        checks++;
        if (blk_remaining !== 16'd3 || dat_write !== 1'b0)
            $display("[TB] FAIL mr_load: got rem=%0d wr=%0b, required 3 0", blk_remaining, dat_write);
        else passes++;
        tick();
        tick();
        pulse_cmd_done(1'b0);
        for (int b = 0; b < 3; b++) begin
            checks++;
            if (dat_start !== 1'b1)
                $display("[TB] FAIL mr_dat_start_%0d: got %0b, required 1", b, dat_start);
            else passes++;
            tick();
            tick();
            pulse_dat_done(1'b0);
            checks++;
            if (blk_remaining !== 16'(2 - b))
                $display("[TB] FAIL mr_rem_%0d: got %0d, required %0d", b, blk_remaining, 2 - b);
            else passes++;
        end
`ifdef SD_AUTO_CMD12_EN
        checks++;
        if ({cmd_start, cmd_index_o} !== {1'b1, 6'd12} || cmd_arg_o !== 32'd0 || xfer_done !== 1'b0)
            $display("[TB] FAIL mr_cmd12: got start=%0b idx=%0d arg=%0h done=%0b, required 1 12 0 0",
                     cmd_start, cmd_index_o, cmd_arg_o, xfer_done);
        else passes++;
        tick();
        tick();
        pulse_cmd_done(1'b0);
`endif
        checks++;
        if ({xfer_done, busy} !== 2'b10)
            $display("[TB] FAIL mr_done: got done/busy=%b, required 10", {xfer_done, busy});
        else passes++;
        tick();
        checks++;
        if (n_dat_start - d0 !== 3 || n_xfer_done - x0 !== 1)
            $display("[TB] FAIL mr_counts: got dat_starts=%0d xfer_dones=%0d, required 3 1",
                     n_dat_start - d0, n_xfer_done - x0);
        else passes++;
`ifdef SD_AUTO_CMD12_EN
        checks++;
        if (n_cmd_start - c0 !== 2)
            $display("[TB] FAIL mr_cmd_starts: got %0d, required 2", n_cmd_start - c0);
        else passes++;
`else
        checks++;
        if (n_cmd_start - c0 !== 1)
            $display("[TB] FAIL mr_cmd_starts: got %0d, required 1", n_cmd_start - c0);
        else passes++;
`endif
    endtask

    task automatic test_cmd_err();
        int d0 = n_dat_start;
        issue_req(6'd17, 32'h40, 1'b1, 1'b0, 16'd2);
        tick();
        pulse_cmd_done(1'b1);
        checks++;
        if ({err_pulse, busy, err_code} !== {1'b1, 1'b0, 3'd1})
            $display("[TB] FAIL ce_err: got err=%0b busy=%0b code=%0d, required 1 0 1", err_pulse, busy, err_code);
        else passes++;
        repeat (3) tick();
        checks++;
        if (err_pulse !== 1'b0 || err_code !== 3'd1 || n_dat_start - d0 !== 0)
            $display("[TB] FAIL ce_after: got err=%0b code=%0d dat_starts=%0d, required 0 1 0",
                     err_pulse, err_code, n_dat_start - d0);
        else passes++;
    endtask

    task automatic test_dat_err();
        int d0 = n_dat_start;
        issue_req(6'd25, 32'h800, 1'b1, 1'b1, 16'd4);
        checks++;
        if (dat_write !== 1'b1 || err_code !== 3'd0)
            $display("[TB] FAIL de_load: got wr=%0b code=%0d, required 1 0", dat_write, err_code);
        else passes++;
        tick();
        pulse_cmd_done(1'b0);
        tick();
        pulse_dat_done(1'b0);
        tick();
        pulse_dat_done(1'b1);
        checks++;
        if ({err_pulse, busy, err_code} !== {1'b1, 1'b0, 3'd3} || blk_remaining !== 16'd3)
            $display("[TB] FAIL de_err: got err=%0b busy=%0b code=%0d rem=%0d, required 1 0 3 3",
                     err_pulse, busy, err_code, blk_remaining);
        else passes++;
        repeat (3) tick();
        checks++;
        if (n_dat_start - d0 !== 2)
            $display("[TB] FAIL de_starts: got %0d, required 2", n_dat_start - d0);
        else passes++;
    endtask

    task automatic test_timeout();
        issue_req(6'd17, 32'h0, 1'b1, 1'b0, 16'd1);
        tick();
        pulse_cmd_done(1'b0);
        tick();
        repeat (15) tick();
        checks++;
        if ({busy, err_pulse} !== 2'b10)
            $display("[TB] FAIL to_dat_c16: got busy/err=%b, required 10", {busy, err_pulse});
        else passes++;
        tick();
        checks++;
        if ({err_pulse, err_code} !== {1'b1, 3'd4})
            $display("[TB] FAIL to_dat: got err=%0b code=%0d, required 1 4", err_pulse, err_code);
        else passes++;
        tick();
        issue_req(6'd17, 32'h0, 1'b1, 1'b0, 16'd1);
        tick();
        pulse_cmd_done(1'b0);
        tick();
        repeat (15) tick();
        pulse_dat_done(1'b0);
        checks++;
        if ({xfer_done, err_pulse, err_code} !== {1'b1, 1'b0, 3'd0} || blk_remaining !== 16'd0)
            $display("[TB] FAIL to_done_wins: got done=%0b err=%0b code=%0d rem=%0d, required 1 0 0 0",
                     xfer_done, err_pulse, err_code, blk_remaining);
        else passes++;
        tick();
        issue_req(6'd2, 32'h0, 1'b0, 1'b0, 16'd0);
        tick();
        repeat (15) tick();
        tick();
        checks++;
        if ({err_pulse, err_code} !== {1'b1, 3'd2})
            $display("[TB] FAIL to_cmd: got err=%0b code=%0d, required 1 2", err_pulse, err_code);
        else passes++;
        tick();
    endtask

    task automatic test_reset_mid_xfer();
        logic [63:0] outs;
        int x0;
        int e0;
        issue_req(6'd25, 32'hABC, 1'b1, 1'b1, 16'd2);
        tick();
        pulse_cmd_done(1'b0);
        tick();
        checks++;
        if ({busy, dat_write} !== 2'b11 || blk_remaining !== 16'd2)
            $display("[TB] FAIL rm_pre: got busy=%0b wr=%0b rem=%0d, required 1 1 2", busy, dat_write, blk_remaining);
        else passes++;
        x0 = n_xfer_done;
        e0 = n_err_pulse;
        #2;
        RESET = 1'b1;
        #1;
        outs = {cmd_start, dat_start, dat_write, busy, xfer_done, err_pulse, err_code,
                blk_remaining, cmd_index_o};
        checks++;
        if (outs !== 64'd0 || cmd_arg_o !== 32'd0)
            $display("[TB] FAIL rm_outputs: got %0h/%0h, required 0/0", outs, cmd_arg_o);
        else passes++;
        tick();
        RESET = 1'b0;
        tick();
        checks++;
        if (n_xfer_done !== x0 || n_err_pulse !== e0)
            $display("[TB] FAIL rm_no_pulse: got done/err deltas %0d/%0d, required 0/0",
                     n_xfer_done - x0, n_err_pulse - e0);
        else passes++;
        issue_req(6'd5, 32'h55, 1'b0, 1'b0, 16'd0);
        tick();
        pulse_cmd_done(1'b0);
        checks++;
        if (xfer_done !== 1'b1)
            $display("[TB] FAIL rm_rerun: got done=%0b, required 1", xfer_done);
        else passes++;
        tick();
    endtask

    task automatic test_back_to_back();
        int c0;
        issue_req(6'd5, 32'h55, 1'b0, 1'b0, 16'd0);
        tick();
        req_go = 1'b1; req_index = 6'd9; req_arg = 32'h99;
        req_has_data = 1'b1; req_blk_cnt = 16'd7;
        tick();
        req_go = 1'b0;
        checks++;
        if (cmd_index_o !== 6'd5 || cmd_arg_o !== 32'h55 || blk_remaining !== 16'd0 || busy !== 1'b1)
            $display("[TB] FAIL bb_busy_go: got idx=%0d arg=%0h rem=%0d busy=%0b, required 5 55 0 1",
                     cmd_index_o, cmd_arg_o, blk_remaining, busy);
        else passes++;
        dat_blk_done = 1'b1; dat_err = 1'b1;
        tick();
        dat_blk_done = 1'b0; dat_err = 1'b0;
        checks++;
        if ({busy, err_pulse, dat_start} !== 3'b100)
            $display("[TB] FAIL bb_stray_done: got busy/err/dstart=%b, required 100", {busy, err_pulse, dat_start});
        else passes++;
        pulse_cmd_done(1'b0);
        c0 = n_cmd_start;
        req_go = 1'b1;
        tick();
        req_go = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || cmd_start !== 1'b0 || n_cmd_start !== c0)
            $display("[TB] FAIL bb_go_in_done: got busy=%0b start=%0b new_starts=%0d, required 0 0 0",
                     busy, cmd_start, n_cmd_start - c0);
        else passes++;
    endtask

    initial begin
        RESET = 1'b1;
        req_go = 1'b0; req_index = '0; req_arg = '0; req_has_data = 1'b0;
        req_write = 1'b0; req_blk_cnt = '0;
        cmd_done = 1'b0; cmd_err = 1'b0; dat_blk_done = 1'b0; dat_err = 1'b0;
        test_reset();
        test_non_data();
        test_multi_read();
        test_cmd_err();
        test_dat_err();
        test_timeout();
        test_reset_mid_xfer();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
